// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Loader states depend on IMEM_LOADER_CHECKSUM_EN, which adds the checksum state.
package mips_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StData,
        StChk,
        StDone,
        StErr
    } loader_state_e;
`else
    typedef enum logic [2:0] {
        StIdle,
        StCntHi,
        StCntLo,
        StData,
        StDone,
        StErr
    } loader_state_e;
`endif

endpackage

// File: rtl/byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream.
// o_word_valid pulses for one cycle after the 4th byte of a word is taken.
module byte_packer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [31:0] r_shift;
    logic [1:0]  r_cnt;
    logic        r_word_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift      <= '0;
            r_cnt        <= '0;
            r_word_valid <= 1'b0;
        end else begin
            r_word_valid <= i_valid && (r_cnt == 2'd3);
            if (i_valid) begin
                r_shift <= {r_shift[23:0], i_byte};
                r_cnt   <= r_cnt + 2'd1;
            end
        end
    end

    assign o_last_byte  = (r_cnt == 2'd3);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/count/payload frames and writes words into instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned MAX_COUNT = 32'd1 << ADDR_W;

    loader_state_e     r_state;
    loader_state_e     w_state_next;
    logic [7:0]        r_cnt_hi;
    logic [15:0]       r_words_left;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       w_count;
    logic              w_count_bad;
    logic              w_accept;
    logic              w_pack_valid;
    logic              w_last_byte;
    logic              w_word_valid;
    logic [31:0]       w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
`endif

    assign w_accept     = in_valid && in_ready;
    assign w_count      = {r_cnt_hi, in_data};
    assign w_count_bad  = (w_count == 16'd0) || (32'(w_count) > MAX_COUNT);
    // Bytes past the last payload word never reach the packer.
    assign w_pack_valid = w_accept && (r_state == StData) && (r_words_left != 16'd0);

    byte_packer u_byte_packer (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .i_valid      (w_pack_valid),
        .i_byte       (in_data),
        .o_last_byte  (w_last_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (w_accept && (in_data == SYNC_BYTE)) w_state_next = StCntHi;
            StCntHi: if (w_accept) w_state_next = StCntLo;
            StCntLo: if (w_accept) w_state_next = w_count_bad ? StErr : StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
            StData: begin
                if (w_pack_valid && w_last_byte && (r_words_left == 16'd1)) begin
                    w_state_next = StChk;
                end
            end
            StChk:   if (w_accept) w_state_next = (in_data == r_xor) ? StDone : StErr;
`else
            StData:  if (w_word_valid && (r_words_left == 16'd0)) w_state_next = StDone;
`endif
            StDone:  if (start) w_state_next = StIdle;
            StErr:   if (start) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= StIdle;
            r_cnt_hi     <= '0;
            r_words_left <= '0;
            r_addr       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if ((r_state == StCntHi) && w_accept) r_cnt_hi <= in_data;
            if ((r_state == StCntLo) && w_accept) begin
                r_words_left <= w_count;
                r_addr       <= '0;
            end
            if (w_pack_valid && w_last_byte) r_words_left <= r_words_left - 16'd1;
            // Words-left already reads zero during the final strobe, so the address never wraps.
            if (w_word_valid && (r_words_left != 16'd0)) r_addr <= r_addr + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if ((r_state == StCntLo) && w_accept) begin
                r_xor <= '0;
            end else if (w_pack_valid) begin
                r_xor <= r_xor ^ in_data;
            end
`endif
        end
    end

    assign in_ready  = (r_state != StDone) && (r_state != StErr);
    assign im_we     = w_word_valid;
    assign im_addr   = r_addr;
    assign im_wdata  = w_word;
    assign cpu_reset = (r_state != StDone);
    assign done      = (r_state == StDone);
    assign error     = (r_state == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (ADDR_W=8 and ADDR_W=2).
// Define IMEM_LOADER_CHECKSUM_EN to also exercise the checksum frames.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [1:0]  in_valid;
    logic [7:0]  in_data [2];
    wire  [1:0]  in_ready;
    wire  [1:0]  im_we;
    wire  [1:0]  cpu_reset;
    wire  [1:0]  done;
    wire  [1:0]  error;
    wire  [7:0]  im_addr_a;
    wire  [1:0]  im_addr_b;
    wire  [31:0] im_wdata_a;
    wire  [31:0] im_wdata_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [39:0] exp_q0 [$];
    logic [39:0] exp_q1 [$];
    logic [31:0] words_q [$];

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start[0]),
        .in_valid  (in_valid[0]),
        .in_data   (in_data[0]),
        .in_ready  (in_ready[0]),
        .im_we     (im_we[0]),
        .im_addr   (im_addr_a),
        .im_wdata  (im_wdata_a),
        .cpu_reset (cpu_reset[0]),
        .done      (done[0]),
        .error     (error[0])
    );

    imem_loader #(.ADDR_W(2)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start[1]),
        .in_valid  (in_valid[1]),
        .in_data   (in_data[1]),
        .in_ready  (in_ready[1]),
        .im_we     (im_we[1]),
        .im_addr   (im_addr_b),
        .im_wdata  (im_wdata_b),
        .cpu_reset (cpu_reset[1]),
        .done      (done[1]),
        .error     (error[1])
    );

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (im_we[0] === 1'b1) begin
            n_tests++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL wr_a unexpected: got %0h expected none", {im_addr_a, im_wdata_a});
            end else begin
                logic [39:0] e0;
                e0 = exp_q0.pop_front();
                if ({im_addr_a, im_wdata_a} !== e0) begin
                    n_fail++;
                    $display("FAIL wr_a: got %0h expected %0h", {im_addr_a, im_wdata_a}, e0);
                end
            end
        end
        if (im_we[1] === 1'b1) begin
            n_tests++;
            if (exp_q1.size() == 0) begin
                n_fail++;
                $display("FAIL wr_b unexpected: got %0h expected none",
                         {6'b0, im_addr_b, im_wdata_b});
            end else begin
                logic [39:0] e1;
                e1 = exp_q1.pop_front();
                if ({6'b0, im_addr_b, im_wdata_b} !== e1) begin
                    n_fail++;
                    $display("FAIL wr_b: got %0h expected %0h", {6'b0, im_addr_b, im_wdata_b}, e1);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input int s, input logic [7:0] b);
        int  n  = 0;
        bit  ok = 1'b0;
        in_valid[s] = 1'b1;
        in_data[s]  = b;
        while (!ok && n < 50) begin
            ok = (in_ready[s] === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        in_valid[s] = 1'b0;
        if (!ok) check("send_byte_timeout", 40'd0, 40'd1);
    endtask

    task automatic push_exp(input int s, input logic [7:0] addr, input logic [31:0] data);
        if (s == 0) exp_q0.push_back({addr, data});
        else        exp_q1.push_back({addr, data});
    endtask

    task automatic send_frame(input int s, input int gap);
        logic [15:0] cnt;
        logic [31:0] w;
        logic [7:0]  x;
        cnt = 16'(words_q.size());
        x   = 8'h00;
        for (int i = 0; i < words_q.size(); i++) push_exp(s, 8'(i), words_q[i]);
        send_byte(s, 8'hA5);
        send_byte(s, cnt[15:8]);
        send_byte(s, cnt[7:0]);
        for (int i = 0; i < words_q.size(); i++) begin
            w = words_q[i];
            for (int k = 3; k >= 0; k--) begin
                x = x ^ w[8*k +: 8];
                send_byte(s, w[8*k +: 8]);
                idle(gap);
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(s, x);
`endif
    endtask

    task automatic wait_flag(input int s, input bit want_err, input string name);
        int n = 0;
        while (((want_err ? error[s] : done[s]) !== 1'b1) && n < 200) begin
            idle(1);
            n++;
        end
        check(name, {39'd0, (want_err ? error[s] : done[s])}, 40'd1);
    endtask

    task automatic check_status(input int s, input string name,
                                input logic rdy, input logic cr, input logic dn, input logic er);
        check({name, "_in_ready"}, {39'd0, in_ready[s]}, {39'd0, rdy});
        check({name, "_cpu_reset"}, {39'd0, cpu_reset[s]}, {39'd0, cr});
        check({name, "_done"}, {39'd0, done[s]}, {39'd0, dn});
        check({name, "_error"}, {39'd0, error[s]}, {39'd0, er});
    endtask

    task automatic pulse_start(input int s);
        start[s] = 1'b1;
        idle(1);
        start[s] = 1'b0;
        check_status(s, "after_start", 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        start    = 2'b00;
        in_valid = 2'b00;
        in_data[0] = 8'h00;
        in_data[1] = 8'h00;
        #2;
        check_status(0, "reset", 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_im_we", {39'd0, im_we[0]}, 40'd0);
        check("reset_im_addr", {32'd0, im_addr_a}, 40'd0);
        check("reset_im_wdata", {8'd0, im_wdata_a}, 40'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);

        // Three-word program.
        words_q = {32'h00221820, 32'h00626022, 32'h8C280000};
        send_frame(0, 0);
        wait_flag(0, 1'b0, "frame3_done");
        check_status(0, "frame3", 1'b0, 1'b0, 1'b1, 1'b0);
        check("frame3_pending", 40'(exp_q0.size()), 40'd0);
        idle(2);
        pulse_start(0);

        // Leading garbage is discarded; strobe and DONE timing.
        send_byte(0, 8'h00);
        send_byte(0, 8'hFF);
        check_status(0, "garbage", 1'b1, 1'b1, 1'b0, 1'b0);
        words_q = {32'h08000004};
        send_frame(0, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("strobe_timing", {39'd0, im_we[0]}, 40'd1);
        idle(1);
        check("done_timing", {39'd0, done[0]}, 40'd1);
`endif
        wait_flag(0, 1'b0, "garbage_done");
        pulse_start(0);

        // Zero count is rejected, then recovery with a stalled two-word frame.
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h00);
        idle(1);
        check_status(0, "zero_cnt", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start(0);
        words_q = {32'h12345678, 32'hCAFEF00D};
        send_frame(0, 2);
        wait_flag(0, 1'b0, "stall_done");
        check_status(0, "stall", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start(0);

        // Count 257 exceeds 2^8.
        send_byte(0, 8'hA5);
        send_byte(0, 8'h01);
        send_byte(0, 8'h01);
        wait_flag(0, 1'b1, "cnt257_err");
        pulse_start(0);

        // Reset mid-frame drops the partial word.
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h01);
        send_byte(0, 8'hDE);
        send_byte(0, 8'hAD);
        #2;
        reset = 1'b0;
        #2;
        check_status(0, "midreset", 1'b1, 1'b1, 1'b0, 1'b0);
        check("midreset_im_we", {39'd0, im_we[0]}, 40'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(1);
        words_q = {32'hDEADBEEF};
        send_frame(0, 0);
        wait_flag(0, 1'b0, "resend_done");
        check_status(0, "resend", 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start(0);
        push_exp(0, 8'h00, 32'h12345678);
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h01);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        send_byte(0, 8'h56);
        send_byte(0, 8'h78);
        send_byte(0, 8'h08);
        wait_flag(0, 1'b0, "chk_ok_done");
        pulse_start(0);
        push_exp(0, 8'h00, 32'h12345678);
        send_byte(0, 8'hA5);
        send_byte(0, 8'h00);
        send_byte(0, 8'h01);
        send_byte(0, 8'h12);
        send_byte(0, 8'h34);
        send_byte(0, 8'h56);
        send_byte(0, 8'h78);
        send_byte(0, 8'h09);
        wait_flag(0, 1'b1, "chk_bad_err");
        check("chk_bad_written", 40'(exp_q0.size()), 40'd0);
`endif

        // ADDR_W=2: count 5 rejected, count 4 fills addresses 0..3.
        send_byte(1, 8'hA5);
        send_byte(1, 8'h00);
        send_byte(1, 8'h05);
        wait_flag(1, 1'b1, "b_cnt5_err");
        check_status(1, "b_cnt5", 1'b0, 1'b1, 1'b0, 1'b1);
        pulse_start(1);
        words_q = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send_frame(1, 0);
        wait_flag(1, 1'b0, "b_cnt4_done");
        check_status(1, "b_cnt4", 1'b0, 1'b0, 1'b1, 1'b0);
        check("b_addr_final", {38'd0, im_addr_b}, 40'd3);

        idle(3);
        check("pending_a", 40'(exp_q0.size()), 40'd0);
        check("pending_b", 40'(exp_q1.size()), 40'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
